// File: rtl/tinyqv_timer_multi.sv
// Free-running prescaled time counter with NCMP compare channels (one-shot or auto-reload),
// sticky W1C pending flags and a single masked interrupt. WIDTH must cover control bits 8+NCMP.
module tinyqv_timer_multi #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NCMP     = 2,
  parameter int unsigned PRE_BITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             time_pulse_i,
  input  logic             wr_en_i,
  input  logic [4:0]       addr_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             timer_interrupt_o
);

  logic [WIDTH-1:0]               mtime_q, mtime_d;
  logic [PRE_BITS-1:0]            prescale_q, prescale_d;
  logic [PRE_BITS-1:0]            pre_cnt_q, pre_cnt_d;
  logic [NCMP-1:0][WIDTH-1:0]     cmp_q, cmp_d;
  logic [NCMP-1:0][WIDTH-1:0]     period_q, period_d;
  logic [NCMP-1:0]                ch_en_q, ch_en_d;
  logic [NCMP-1:0]                periodic_q, periodic_d;
  logic [NCMP-1:0]                pending_q, pending_d;
  logic [NCMP-1:0]                match_q, match_d;

  logic                           tick;
  logic                           wr_mtime, wr_pre, wr_pend, wr_ctrl;
  logic [NCMP-1:0]                wr_cmp, wr_period;
  logic [NCMP-1:0]                rise;
  logic [NCMP-1:0][WIDTH-1:0]     diff;

  always_comb begin
    wr_mtime = wr_en_i && (addr_i == 5'd0);
    wr_pre   = wr_en_i && (addr_i == 5'd1);
    wr_pend  = wr_en_i && (addr_i == 5'd2);
    wr_ctrl  = wr_en_i && (addr_i == 5'd3);
    wr_cmp    = '0;
    wr_period = '0;
    for (int i = 0; i < NCMP; i++) begin
      wr_cmp[i]    = wr_en_i && (addr_i == 5'(4 + 2 * i));
      wr_period[i] = wr_en_i && (addr_i == 5'(5 + 2 * i));
    end
  end

  // Prescaler and time counter
  always_comb begin
    tick       = time_pulse_i && (pre_cnt_q == prescale_q);
    prescale_d = wr_pre ? data_in_i[PRE_BITS-1:0] : prescale_q;
    pre_cnt_d  = pre_cnt_q;
    if (wr_pre) begin
      pre_cnt_d = '0;
    end else if (time_pulse_i) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_BITS'(1);
    end
    mtime_d = mtime_q;
    if (wr_mtime) begin
      mtime_d = data_in_i;
    end else if (tick) begin
      mtime_d = mtime_q + WIDTH'(1);
    end
  end

  // Compare channels: window match is wrap-safe since it looks only at the top two diff bits
  always_comb begin
    diff       = '0;
    match_d    = '0;
    cmp_d      = cmp_q;
    period_d   = period_q;
    ch_en_d    = wr_ctrl ? data_in_i[NCMP-1:0] : ch_en_q;
    periodic_d = wr_ctrl ? data_in_i[8 +: NCMP] : periodic_q;
    for (int i = 0; i < NCMP; i++) begin
      diff[i]    = mtime_q - cmp_q[i];
      match_d[i] = ch_en_q[i] && (diff[i][WIDTH-1 -: 2] == 2'b00);
    end
    rise = match_d & ~match_q;
    for (int i = 0; i < NCMP; i++) begin
      if (wr_cmp[i]) begin
        cmp_d[i] = data_in_i;
      end else if (rise[i] && periodic_q[i]) begin
        cmp_d[i] = cmp_q[i] + period_q[i];
      end
      if (wr_period[i]) begin
        period_d[i] = data_in_i;
      end
    end
    // Set has priority over a coincident W1C
    pending_d = (pending_q & ~(wr_pend ? data_in_i[NCMP-1:0] : '0)) | rise;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      cmp_q      <= '0;
      period_q   <= '0;
      ch_en_q    <= '0;
      periodic_q <= '0;
      pending_q  <= '0;
      match_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      ch_en_q    <= ch_en_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      match_q    <= match_d;
    end
  end

  always_comb begin
    data_out_o = '0;
    case (addr_i)
      5'd0: data_out_o = mtime_q;
      5'd1: data_out_o = WIDTH'(prescale_q);
      5'd2: data_out_o = WIDTH'(pending_q);
      5'd3: begin
        data_out_o[NCMP-1:0] = ch_en_q;
        data_out_o[8 +: NCMP] = periodic_q;
      end
      default: begin
        for (int i = 0; i < NCMP; i++) begin
          if (addr_i == 5'(4 + 2 * i)) data_out_o = cmp_q[i];
          if (addr_i == 5'(5 + 2 * i)) data_out_o = period_q[i];
        end
      end
    endcase
  end

  assign timer_interrupt_o = |(pending_q & ch_en_q);

endmodule

// File: tb/tb_tinyqv_timer_multi.sv
// Scoreboard bench for tinyqv_timer_multi: directed scenarios then random traffic vs a
// behavioural register-level model.
module tb_tinyqv_timer_multi;
  localparam int W = 32;
  localparam int N = 2;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         time_pulse, wr_en;
  logic [4:0]   addr;
  logic [W-1:0] data_in, data_out;
  logic         irq;

  tinyqv_timer_multi #(.WIDTH(W), .NCMP(N), .PRE_BITS(P)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .time_pulse_i     (time_pulse),
    .wr_en_i          (wr_en),
    .addr_i           (addr),
    .data_in_i        (data_in),
    .data_out_o       (data_out),
    .timer_interrupt_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] data;
    logic         irq;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state
  logic [W-1:0] m_time;
  logic [W-1:0] m_cmp[N];
  logic [W-1:0] m_per[N];
  logic [P-1:0] m_pre, m_cnt;
  logic [N-1:0] m_en, m_pm, m_pend, m_prev;

  task automatic m_reset();
    m_time = '0; m_pre = '0; m_cnt = '0;
    m_en = '0; m_pm = '0; m_pend = '0; m_prev = '0;
    for (int i = 0; i < N; i++) begin
      m_cmp[i] = '0;
      m_per[i] = '0;
    end
  endtask

  function automatic bit in_win(int i);
    logic [W-1:0] d;
    d = m_time - m_cmp[i];
    return m_en[i] && (longint'(d) < (longint'(1) << (W - 2)));
  endfunction

  function automatic logic [W-1:0] m_read(logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return m_time;
    if (ai == 1) return W'(m_pre);
    if (ai == 2) return W'(m_pend);
    if (ai == 3) return W'(m_en) | (W'(m_pm) << 8);
    if (ai >= 4 && ai < 4 + 2 * N) begin
      if ((ai - 4) % 2 == 0) return m_cmp[(ai - 4) / 2];
      return m_per[(ai - 4) / 2];
    end
    return '0;
  endfunction

  task automatic m_step(bit r, bit p, bit w, logic [4:0] a, logic [W-1:0] d);
    bit           tick;
    logic [N-1:0] win, rise;
    int           ai;
    ai = int'(a);
    if (r) begin
      m_reset();
      return;
    end
    tick = p && (m_cnt == m_pre);
    for (int i = 0; i < N; i++) win[i] = in_win(i);
    rise = win & ~m_prev;
    if (w && ai == 2) m_pend = m_pend & ~d[N-1:0];
    m_pend = m_pend | rise;
    for (int i = 0; i < N; i++) begin
      if (w && ai == 4 + 2 * i) m_cmp[i] = d;
      else if (rise[i] && m_pm[i]) m_cmp[i] = m_cmp[i] + m_per[i];
      if (w && ai == 5 + 2 * i) m_per[i] = d;
    end
    if (w && ai == 0) m_time = d;
    else if (tick) m_time = m_time + 1;
    if (w && ai == 1) begin
      m_pre = d[P-1:0];
      m_cnt = '0;
    end else if (p) begin
      m_cnt = tick ? '0 : m_cnt + 1;
    end
    if (w && ai == 3) begin
      m_en = d[N-1:0];
      m_pm = d[8 +: N];
    end
    m_prev = win;
  endtask

  // One bus cycle: the read of addr is expected either from the model or as a fixed constant
  task automatic cyc(input bit p, input bit w, input logic [4:0] a, input logic [W-1:0] d,
                     input string nm = "", input bit use_const = 0,
                     input logic [W-1:0] cval = '0);
    exp_t e;
    time_pulse = p; wr_en = w; addr = a; data_in = d;
    e.name = (nm == "") ? $sformatf("rd_a%0d", a) : nm;
    e.data = use_const ? cval : m_read(a);
    e.irq  = |(m_pend & m_en);
    q.push_back(e);
    @(posedge clk);
    m_step(rst, p, w, a, d);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [W-1:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic pulse(input int n);
    repeat (n) cyc(1'b1, 1'b0, 5'd0, '0);
  endtask

  task automatic chk(input string nm, input logic [4:0] a, input logic [W-1:0] v);
    cyc(1'b0, 1'b0, a, '0, nm, 1'b1, v);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (data_out !== e.data || irq !== e.irq) begin
        errors++;
        $display("FAIL %s: data_out=%h irq=%b, expected data_out=%h irq=%b",
                 e.name, data_out, irq, e.data, e.irq);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; time_pulse = 1'b0; wr_en = 1'b0; addr = '0; data_in = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_mtime", 0, 0);
    chk("reset_pend", 2, 0);

    // Prescaler
    wr(1, 3);
    pulse(12);
    chk("presc_mtime3", 0, 3);
    pulse(2);
    wr(1, 3);
    pulse(3);
    chk("presc_restart", 0, 3);
    pulse(1);
    chk("presc_tick4", 0, 4);

    // One-shot channel 0
    wr(1, 0);
    wr(0, 9);
    wr(4, 10);
    wr(3, 1);
    chk("os_idle", 2, 0);
    pulse(1);
    chk("os_edge_cycle", 2, 0);
    chk("os_set", 2, 1);
    wr(2, 1);
    chk("os_w1c", 2, 0);
    pulse(2);
    chk("os_no_rearm", 2, 0);

    // Periodic channel 1
    wr(6, 5);
    wr(7, 4);
    wr(0, 4);
    wr(3, 32'h202);
    pulse(1);
    chk("per_cmp5", 6, 5);
    chk("per_reload9", 6, 9);
    chk("per_set5", 2, 2);
    wr(2, 2);
    pulse(4);
    wr(2, 2);
    chk("per_set_wins", 2, 2);
    chk("per_reload13", 6, 13);
    wr(2, 2);
    pulse(4);
    chk("per_pre13", 2, 0);
    chk("per_reload17", 6, 17);
    chk("per_set13", 2, 2);

    // Asynchronous reset with IRQ high
    rst = 1'b1;
    m_reset();
    chk("rst_pend", 2, 0);
    chk("rst_mtime", 0, 0);
    rst = 1'b0;
    chk("rst_cmp1", 6, 0);

    // Wrap-around
    wr(4, 1);
    wr(0, 32'hFFFF_FFFE);
    wr(3, 1);
    cyc(1'b1, 1'b0, 5'd2, '0, "wrap_t0", 1'b1, 0);
    cyc(1'b1, 1'b0, 5'd2, '0, "wrap_t1", 1'b1, 0);
    cyc(1'b1, 1'b0, 5'd2, '0, "wrap_t2", 1'b1, 0);
    chk("wrap_edge_cycle", 2, 0);
    chk("wrap_set", 2, 1);
    chk("wrap_mtime", 0, 1);

    // Collisions
    cyc(1'b1, 1'b1, 5'd0, 100);
    chk("mtime_coll", 0, 100);
    wr(6, 200);
    wr(7, 4);
    wr(0, 199);
    wr(3, 32'h203);
    pulse(1);
    wr(6, 500);
    chk("cmp_coll", 6, 500);
    chk("coll_pend", 2, 3);
    wr(3, 32'h200);
    chk("disable_pend", 2, 3);
    wr(8, 7);
    chk("oor_read", 8, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bit           p, w;
      logic [4:0]   a;
      logic [W-1:0] d;
      p = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0);
      a = 5'($urandom_range(0, 9));
      case (a)
        5'd0:       d = W'($urandom_range(0, 40));
        5'd1:       d = W'($urandom_range(0, 3));
        5'd2:       d = W'($urandom_range(0, 3));
        5'd3:       d = W'($urandom) & 32'h0303;
        5'd4, 5'd6: d = m_time + W'($urandom_range(0, 12));
        default:    d = W'($urandom_range(0, 8));
      endcase
      cyc(p, w, a, d);
    end

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
